// File: rtl/bitty_exec_ctrl.sv
// Bitty operand-fetch/sequencing/writeback stage with an 8-entry register file; 5 cycles per instruction, no overlap.
// instr_ready is high only in IDLE; preloads are taken only in IDLE and silently dropped otherwise.
module bitty_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    input  logic              reg_wr_en,
    input  logic [2:0]        reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WB
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] regs [8];

    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [2:0]        sel;
    logic [1:0]        fmt;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic              illegal;

    // Ry and the immediate overlap in the instruction word; the format picks one.
    assign rx      = instr_q[15:13];
    assign ry      = instr_q[12:10];
    assign imm     = instr_q[5 +: IMM_W];
    assign sel     = instr_q[4:2];
    assign fmt     = instr_q[1:0];
    assign illegal = fmt[1];
    assign imm_ext = DATA_W'(imm);

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = illegal ? IDLE : LOAD_B;
            LOAD_B:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            instr_q  <= '0;
            result_q <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                    if (reg_wr_en) regs[reg_wr_addr] <= reg_wr_data;
                end
                LOAD_A: begin
                    if (illegal) begin
                        err <= 1'b1;
                    end else begin
                        alu_a   <= regs[rx];
                        alu_sel <= sel;
                    end
                end
                LOAD_B:  alu_b <= (fmt == 2'b00) ? regs[ry] : imm_ext;
                EXEC:    result_q <= alu_result;
                WB: begin
                    regs[rx] <= result_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
